// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART TX channel arbiter.
package uart_arb_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } arb_state_e;

  localparam logic [7:0]  EOP_BYTE_DEFAULT = 8'h0A;
  localparam int unsigned BURST_W          = 8;
  localparam int unsigned IDLE_W           = 16;

endpackage

// File: rtl/uart_tx_arbiter_rr_select.sv
// Round-robin pick: first asserted request scanning last+1, last+2, ... modulo N_REQ.
module rr_select #(
  parameter int unsigned N_REQ = 2,
  parameter int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] last,
  output logic [IDX_W-1:0] pick,
  output logic             any
);

  always_comb begin
    logic        found;
    int unsigned cand;
    pick  = '0;
    found = 1'b0;
    cand  = 0;
    for (int unsigned off = 1; off <= N_REQ; off++) begin
      cand = (32'(last) + off) % N_REQ;
      if (!found && req[IDX_W'(cand)]) begin
        pick  = IDX_W'(cand);
        found = 1'b1;
      end
    end
    any = |req;
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Message-atomic round-robin arbiter sharing one uart_tx byte channel between N_REQ streams.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int unsigned N_REQ        = 2,
  parameter logic [7:0]  EOP_BYTE     = EOP_BYTE_DEFAULT,
  parameter int unsigned MAX_BURST    = 64,
  parameter int unsigned IDLE_TIMEOUT = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [8*N_REQ-1:0] req_data,
  output logic [N_REQ-1:0]   req_ready,
  output logic               tx_valid,
  output logic [7:0]         tx_data,
  input  logic               tx_ready,
  output logic [N_REQ-1:0]   grant,
  output logic               busy
);

  localparam int unsigned         IDX_W      = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [BURST_W-1:0]  BURST_LAST = BURST_W'(MAX_BURST - 1);
  localparam logic [IDLE_W-1:0]   IDLE_LAST  = IDLE_W'(IDLE_TIMEOUT - 1);

  arb_state_e         state_q, state_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic [BURST_W-1:0] burst_cnt_q, burst_cnt_d;
  logic [IDLE_W-1:0]  idle_cnt_q, idle_cnt_d;

  logic [IDX_W-1:0]   pick;
  logic               any_req;
  logic [7:0]         req_bytes [N_REQ];
  logic               locked;
  logic               owner_valid;
  logic [7:0]         owner_byte;
  logic               xfer;

  rr_select #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr_select (
    .req  (req_valid),
    .last (last_q),
    .pick (pick),
    .any  (any_req)
  );

  for (genvar g = 0; g < N_REQ; g++) begin : g_lane
    assign req_bytes[g] = req_data[8*g +: 8];
    assign grant[g]     = locked && (owner_q == IDX_W'(g));
    assign req_ready[g] = grant[g] && tx_ready;
  end

  // Zero-latency pass-through from the owner while locked.
  assign locked      = (state_q == ST_LOCKED);
  assign owner_valid = req_valid[owner_q];
  assign owner_byte  = req_bytes[owner_q];
  assign tx_valid    = locked && owner_valid;
  assign tx_data     = locked ? owner_byte : 8'h00;
  assign busy        = locked;
  assign xfer        = tx_valid && tx_ready;

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    last_d      = last_q;
    burst_cnt_d = burst_cnt_q;
    idle_cnt_d  = idle_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          state_d     = ST_LOCKED;
          owner_d     = pick;
          last_d      = pick;
          burst_cnt_d = '0;
          idle_cnt_d  = '0;
        end
      end
      ST_LOCKED: begin
        if (xfer) begin
          burst_cnt_d = (burst_cnt_q == '1) ? burst_cnt_q : burst_cnt_q + BURST_W'(1);
          idle_cnt_d  = '0;
          if ((owner_byte == EOP_BYTE) || (burst_cnt_q == BURST_LAST)) begin
            state_d = ST_IDLE;
          end
        end else if (!owner_valid) begin
          idle_cnt_d = (idle_cnt_q == '1) ? idle_cnt_q : idle_cnt_q + IDLE_W'(1);
          if (idle_cnt_q == IDLE_LAST) begin
            state_d = ST_IDLE;
          end
        end else begin
          // Owner valid but uart_tx stalled: not idle, keep the grant.
          idle_cnt_d = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      owner_q     <= '0;
      last_q      <= IDX_W'(N_REQ - 1);
      burst_cnt_q <= '0;
      idle_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      burst_cnt_q <= burst_cnt_d;
      idle_cnt_q  <= idle_cnt_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: per-source byte queues plus a rule-level grant model.
module tb_uart_tx_arbiter;

  localparam int         N    = 4;
  localparam int         MAXB = 4;
  localparam int         TO   = 8;
  localparam logic [7:0] EOP  = 8'h0A;

  logic           clk;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic           tx_valid;
  logic [7:0]     tx_data;
  logic           tx_ready;
  logic [N-1:0]   grant;
  logic           busy;

  logic [7:0]   src_q [N][$];
  logic [7:0]   exp_q [N][$];
  logic [N-1:0] glog [$];

  int           total;
  int           bad;
  int           tx_mode;
  logic [N-1:0] en;
  bit           rand_valid;
  int           cyc;
  int           last_xfer_cyc;
  int           fall_cyc;

  uart_tx_arbiter #(
    .N_REQ        (N),
    .EOP_BYTE     (EOP),
    .MAX_BURST    (MAXB),
    .IDLE_TIMEOUT (TO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .tx_valid  (tx_valid),
    .tx_data   (tx_data),
    .tx_ready  (tx_ready),
    .grant     (grant),
    .busy      (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic bit bit_of(input logic [N-1:0] v, input int k);
    return ((v >> k) & N'(1)) != 0;
  endfunction

  // Requester after `last` in circular order that has valid high, or -1.
  function automatic int rr_pick(input logic [N-1:0] v, input int last);
    for (int k = 1; k <= N; k++) begin
      int j;
      j = (last + k) % N;
      if (bit_of(v, j)) return j;
    end
    return -1;
  endfunction

  function automatic int idx_of(input logic [N-1:0] g);
    for (int k = 0; k < N; k++) if (bit_of(g, k)) return k;
    return 0;
  endfunction

  task automatic push_byte(input int i, input logic [7:0] b);
    src_q[i].push_back(b);
    exp_q[i].push_back(b);
  endtask

  // Driver: presents queue heads at negedge, retires accepted bytes just before posedge.
  initial begin
    bit v;
    tx_ready  = 1'b0;
    req_valid = '0;
    req_data  = '0;
    forever begin
      @(negedge clk);
      case (tx_mode)
        0:       tx_ready = 1'b1;
        1:       tx_ready = ~tx_ready;
        2:       tx_ready = 1'($urandom_range(0, 1));
        default: tx_ready = 1'b0;
      endcase
      for (int i = 0; i < N; i++) begin
        v = bit_of(en, i) && (src_q[i].size() > 0) && (!rand_valid || $urandom_range(0, 3) != 0);
        req_valid[i] = v;
        req_data[8*i +: 8] = v ? src_q[i][0] : 8'($urandom);
      end
      #3;
      for (int i = 0; i < N; i++)
        if (req_valid[i] && req_ready[i]) void'(src_q[i].pop_front());
    end
  end

  // Monitor: grant/release rules at message level and per-source byte scoreboard.
  initial begin
    logic [N-1:0] prev_g, prev_valid, exp_g, g, exp_rr;
    bit           prev_rel, ov, xfer;
    int           last_m, cnt_m, idle_m, s, p;
    logic [7:0]   eb;
    prev_g = '0; prev_valid = '0; prev_rel = 0;
    last_m = N - 1; cnt_m = 0; idle_m = 0;
    cyc = 0; last_xfer_cyc = 0; fall_cyc = 0;
    forever begin
      @(negedge clk);
      #3;
      cyc++;
      if (rst) begin
        prev_g = '0; prev_valid = '0; prev_rel = 0;
        last_m = N - 1; cnt_m = 0; idle_m = 0;
        continue;
      end
      if (prev_g == '0) begin
        p = rr_pick(prev_valid, last_m);
        exp_g = (p >= 0) ? (N'(1) << p) : '0;
      end else begin
        exp_g = prev_rel ? '0 : prev_g;
      end
      chk("grant", 32'(grant), 32'(exp_g));
      chk("busy", 32'(busy), 32'(exp_g != '0));
      g = exp_g;
      s = idx_of(g);
      if (prev_g == '0 && g != '0) begin
        cnt_m = 0; idle_m = 0; last_m = s;
        glog.push_back(g);
      end
      ov     = (g != '0) && bit_of(req_valid, s);
      exp_rr = (g != '0 && tx_ready) ? g : '0;
      chk("tx_valid", 32'(tx_valid), 32'(ov));
      chk("req_ready", 32'(req_ready), 32'(exp_rr));
      if (g == '0) chk("tx_data_idle", 32'(tx_data), 32'(0));
      xfer = ov && tx_ready;
      prev_rel = 0;
      if (xfer) begin
        if (exp_q[s].size() == 0) begin
          total++; bad++;
          $display("FAIL tx_data_unexpected src=%0d act=%0h exp=none", s, tx_data);
          eb = tx_data;
        end else begin
          eb = exp_q[s].pop_front();
          chk("tx_data", 32'(tx_data), 32'(eb));
        end
        cnt_m++;
        idle_m = 0;
        last_xfer_cyc = cyc;
        prev_rel = (eb == EOP) || (cnt_m == MAXB);
      end else if (g != '0 && !ov) begin
        idle_m++;
        prev_rel = (idle_m == TO);
      end else begin
        idle_m = 0;
      end
      if (prev_g != '0 && g == '0) fall_cyc = cyc;
      prev_g     = g;
      prev_valid = req_valid;
    end
  end

  task automatic drain(input int budget);
    int n;
    bit pending;
    n = 0;
    pending = 1;
    while (pending && n < budget) begin
      @(negedge clk);
      n++;
      pending = busy;
      for (int i = 0; i < N; i++) if (src_q[i].size() > 0) pending = 1;
    end
    chk("drain_in_budget", 32'(n < budget), 32'(1));
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int len;
    int src;
    total = 0; bad = 0;
    tx_mode = 0; en = '0; rand_valid = 0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_tx_valid", 32'(tx_valid), 32'(0));
    chk("rst_tx_data", 32'(tx_data), 32'(0));
    chk("rst_req_ready", 32'(req_ready), 32'(0));
    chk("rst_grant", 32'(grant), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    @(negedge clk);
    rst = 1'b0;

    // Two simultaneous newline-terminated messages: requester 0 first, then 1.
    glog.delete();
    en = 4'b0011;
    push_byte(0, 8'h48); push_byte(0, 8'h49); push_byte(0, 8'h0A);
    push_byte(1, 8'h4F); push_byte(1, 8'h4B); push_byte(1, 8'h0A);
    drain(200);
    chk("t1_ngrants", 32'(glog.size()), 32'(2));
    chk("t1_first", 32'(glog[0]), 32'(4'b0001));
    chk("t1_second", 32'(glog[1]), 32'(4'b0010));

    // Toggling tx_ready, five bytes from requester 0 (burst limit splits after 4).
    glog.delete();
    tx_mode = 1; en = 4'b0001;
    for (int k = 0; k < 5; k++) push_byte(0, 8'(8'h41 + k));
    drain(300);
    chk("t2_ngrants", 32'(glog.size()), 32'(2));
    chk("t2_owner", 32'(glog[1]), 32'(4'b0001));

    // Ten non-EOP bytes from requester 1: grants of 4, 4, 2.
    glog.delete();
    tx_mode = 0; en = 4'b0010;
    for (int k = 0; k < 10; k++) push_byte(1, 8'(8'h30 + k));
    drain(300);
    chk("t3_ngrants", 32'(glog.size()), 32'(3));
    for (int k = 0; k < 3; k++) chk("t3_owner", 32'(glog[k]), 32'(4'b0010));

    // Single byte then silence: grant held for exactly TO cycles after the transfer.
    en = 4'b0001;
    push_byte(0, 8'h41);
    drain(300);
    chk("t4_timeout_cycles", 32'(fall_cyc - last_xfer_cyc - 1), 32'(TO));

    // UART stall with valid high never counts as idle.
    tx_mode = 3;
    push_byte(0, 8'h58); push_byte(0, 8'h59);
    repeat (100) @(negedge clk);
    #1;
    chk("t4_stall_busy", 32'(busy), 32'(1));
    chk("t4_stall_grant", 32'(grant), 32'(4'b0001));
    tx_mode = 0;
    drain(300);

    // Asynchronous reset mid-message.
    en = 4'b0100;
    push_byte(2, 8'h61); push_byte(2, 8'h62); push_byte(2, 8'h63);
    n = 0;
    while (!busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("t5_locked", 32'(busy), 32'(1));
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("t5_tx_valid", 32'(tx_valid), 32'(0));
    chk("t5_tx_data", 32'(tx_data), 32'(0));
    chk("t5_req_ready", 32'(req_ready), 32'(0));
    chk("t5_grant", 32'(grant), 32'(0));
    chk("t5_busy", 32'(busy), 32'(0));
    for (int i = 0; i < N; i++) begin
      src_q[i].delete();
      exp_q[i].delete();
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // All four requesters with back-to-back one-byte messages: strict rotation from 0.
    glog.delete();
    en = 4'b1111;
    for (int r = 0; r < 3; r++)
      for (int i = 0; i < N; i++) push_byte(i, EOP);
    drain(300);
    chk("t6_ngrants", 32'(glog.size()), 32'(3 * N));
    for (int k = 0; k < 3 * N; k++) chk("t6_order", 32'(glog[k]), 32'(N'(1) << (k % N)));

    // Random traffic, random tx_ready, random valid gaps.
    tx_mode = 2; rand_valid = 1;
    for (int m = 0; m < 40; m++) begin
      src = int'($urandom_range(0, N - 1));
      len = int'($urandom_range(1, 6));
      for (int k = 0; k < len - 1; k++) push_byte(src, 8'($urandom_range(32, 126)));
      push_byte(src, ($urandom_range(0, 1) != 0) ? EOP : 8'($urandom_range(32, 126)));
    end
    drain(20000);

    n = 0;
    for (int i = 0; i < N; i++) n += exp_q[i].size();
    chk("bytes_left", 32'(n), 32'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares one `uart_tx` byte channel between `N_REQ` byte-stream requesters, such as the ROT13 echo path and a status/banner generator. It sits between the requesters and `uart_tx`. It grants the channel round-robin and holds each grant for a whole message, so lines from different sources never interleave on TX. The grant is released on an end-of-message byte, a burst limit, or an idle timeout.

## Interface
- `N_REQ`, default 2: number of requesters, 2..8.
- `EOP_BYTE`, default 8'h0A: byte value that ends a message and releases the grant.
- `MAX_BURST`, default 64: maximum bytes per grant before a forced release, 1..255.
- `IDLE_TIMEOUT`, default 1024: consecutive cycles the holder may leave `req_valid` low before release, 1..65535.
- `clk`  in  1: single clock domain.
- `rst`  in  1: asynchronous, active-high reset.
- `req_valid`  in  N_REQ: per-requester byte valid.
- `req_data`  in  8*N_REQ: requester i's byte is `req_data[8*i+7:8*i]`.
- `req_ready`  out  N_REQ: per-requester accept; at most one bit is high.
- `tx_valid`  out  1: to `uart_tx.valid`.
- `tx_data`  out  8: to `uart_tx.data`.
- `tx_ready`  in  1: from `uart_tx.ready`.
- `grant`  out  N_REQ: one-hot current owner; all zeros in IDLE.
- `busy`  out  1: high in LOCKED.

## Operation
- Handshake is valid/ready, matching `uart_tx`.
  - A byte transfers on a cycle where `tx_valid && tx_ready`.
  - Requester i transfers when `req_valid[i] && req_ready[i]`.
  - The two events are identical for the granted requester.
- State machine has two states, IDLE and LOCKED.
- Registers:
  - `state`
  - `owner` index
  - `last` index, the round-robin pointer
  - `burst_cnt`, 8 bits
  - `idle_cnt`, 16 bits
- IDLE:
  - `tx_valid`=0, all `req_ready`=0, `grant`=0.
  - If any `req_valid` is high, pick the first valid requester scanning `last+1, last+2, …` modulo N_REQ.
  - On a pick: `owner`=pick, `last`=pick, `burst_cnt`=0, `idle_cnt`=0, go to LOCKED.
- LOCKED, datapath: combinational pass-through.
  - `tx_valid`=`req_valid[owner]`, `tx_data`=requester `owner`'s byte.
  - `req_ready[owner]`=`tx_ready`; all other `req_ready` bits are 0.
- LOCKED, on a transfer:
  - `burst_cnt` increments and `idle_cnt` clears.
  - Go to IDLE if the byte equals `EOP_BYTE` or `burst_cnt == MAX_BURST-1`.
- LOCKED, `req_valid[owner]`=0: increment `idle_cnt`; go to IDLE when `idle_cnt == IDLE_TIMEOUT-1`.
- LOCKED, `req_valid[owner]`=1 and `tx_ready`=0: this is a UART stall, not idle. Clear `idle_cnt` and do not release.
- Release conditions evaluated in the same cycle are OR-ed. An EOP byte that is also the MAX_BURST-th byte releases once.
- Non-owner requesters may hold `req_valid` high indefinitely. They are not accepted and their data is ignored.
- Widths: counters saturate and never wrap. Release fires before any wrap is possible given the parameter ranges.

## Timing
- Reset values (async assert, sync-safe release):
  - `state`=IDLE, `owner`=0, `last`=N_REQ-1, so requester 0 wins first.
  - counters 0.
  - outputs: `tx_valid`=0, `tx_data`=0, `req_ready`=0, `grant`=0, `busy`=0.
- Arbitration latency: `req_valid` rising in IDLE at cycle t gives `grant`/`busy` high at t+1. The first byte can transfer at t+1.
- Data latency in LOCKED is zero cycles, combinational from requester to `uart_tx`. `tx_ready` to `req_ready` is also combinational.
- Release: the transfer of the releasing byte at cycle t gives IDLE at t+1 and a new grant at t+2. There is exactly one dead IDLE cycle between grants.
- Back-to-back requests from the same single requester: re-granted after the one IDLE cycle.
- Reset mid-message drops the grant immediately. The byte already latched by `uart_tx` is not the arbiter's concern.

## Structure
- Shared package/header `uart_arb_pkg` holds:
  - state encoding constants `ST_IDLE`/`ST_LOCKED`
  - default `EOP_BYTE` (8'h0A)
  - counter width constants (8 and 16)
- One sub-module, `rr_select`: purely combinational.
  - Inputs: `req[N_REQ]`, `last` index.
  - Outputs: `pick` index, `any`.
- Top level holds the FSM, counters, and output muxing.

## Test plan
- Reset, then hold req0 and req1 valid together → grant=01 first. After req0 sends "HI\n" (0x48 0x49 0x0A), exactly one IDLE cycle, then grant=10.
- With `tx_ready` toggling 1/0 every cycle, req0 sends 5 bytes: `tx_data` sequence matches input, no byte duplicated or dropped, `req_ready[1]` stays 0 throughout.
- MAX_BURST=4, req1 streams 10 non-EOP bytes alone → releases after bytes 4 and 8 with one IDLE cycle each; bytes 9 and 10 are sent in the third grant.
- IDLE_TIMEOUT=8, req0 sends 0x41 then drops valid → `busy` falls exactly 8 cycles after the last transfer. Holding `tx_ready`=0 with valid high for 100 cycles does not release.
- Assert `rst` mid-message while LOCKED → all outputs 0 in the same cycle (async). After release, requester 0 has priority again.
- N_REQ=4, all four requesters sending continuously one-byte "\n" messages → grant order 0,1,2,3,0,… with each one-byte message followed by one IDLE cycle.
